// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: rotates (x, y) onto the +x axis one micro-rotation per clock,
// returning atan2(y, x) and the K-scaled magnitude behind a valid/ready handshake on each side.
module cordic_vector #(
  parameter int WIDTH = 32,
  parameter int ITER  = 24
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_in_valid,
  output logic                    io_in_ready,
  input  logic signed [WIDTH-1:0] io_in_x,
  input  logic signed [WIDTH-1:0] io_in_y,
  output logic                    io_out_valid,
  input  logic                    io_out_ready,
  output logic [WIDTH+1:0]        io_out_mag,
  output logic signed [WIDTH-1:0] io_out_angle
);

  localparam int FRAC  = WIDTH - 3;
  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROTATE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // atan(1/n) in Q2.61 by Taylor series; only evaluated at elaboration
  function automatic logic [63:0] atan_inv(input logic [63:0] n);
    logic [63:0] term;
    logic [63:0] sum;
    logic [63:0] n2;
    term = 64'h2000_0000_0000_0000 / n;
    sum  = term;
    n2   = n * n;
    for (int k = 1; k < 32; k++) begin
      term = term / n2;
      if (k % 2 == 1) sum = sum - term / 64'(2 * k + 1);
      else            sum = sum + term / 64'(2 * k + 1);
    end
    return sum;
  endfunction

  function automatic logic signed [WIDTH:0] to_angle(input logic [63:0] q61);
    return (WIDTH+1)'((q61 + (64'd1 << (60 - FRAC))) >> (61 - FRAC));
  endfunction

  // Machin's formula supplies pi/4 for the i=0 entry and the pi constants
  function automatic logic signed [WIDTH:0] atan_c(input int i);
    if (i == 0) return to_angle(4 * atan_inv(64'd5) - atan_inv(64'd239));
    return to_angle(atan_inv(64'd1 << i));
  endfunction

  localparam logic signed [WIDTH:0] PI_Z      = to_angle(16 * atan_inv(64'd5) - 4 * atan_inv(64'd239));
  localparam logic signed [WIDTH:0] HALF_PI_Z = to_angle(8 * atan_inv(64'd5) - 2 * atan_inv(64'd239));

  function automatic logic signed [WIDTH-1:0] sat_angle(input logic signed [WIDTH:0] z);
    if (z > PI_Z)  return PI_Z[WIDTH-1:0];
    if (z < -PI_Z) return -PI_Z[WIDTH-1:0];
    return z[WIDTH-1:0];
  endfunction

  logic signed [WIDTH:0] atan_lut [2**CNT_W];

  for (genvar g = 0; g < 2**CNT_W; g++) begin : g_atan
    localparam logic signed [WIDTH:0] A = (g < ITER) ? atan_c(g) : '0;
    assign atan_lut[g] = A;
  end

  logic [1:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic                    zero_r;
  logic signed [WIDTH+1:0] x_r, y_r;
  logic signed [WIDTH:0]   z_r;

  logic signed [WIDTH+1:0] x_ext, y_ext, pre_x, pre_y, x_sh, y_sh, nx, ny;
  logic signed [WIDTH:0]   pre_z, nz;

  assign io_in_ready = (state == S_IDLE);

  always_comb begin
    x_ext = {{2{io_in_x[WIDTH-1]}}, io_in_x};
    y_ext = {{2{io_in_y[WIDTH-1]}}, io_in_y};
    pre_x = x_ext;
    pre_y = y_ext;
    pre_z = '0;
    // Left half-plane: pre-rotate by +/-pi/2 so the iterations only need to cover +/-pi/2
    if (io_in_x[WIDTH-1]) begin
      if (!io_in_y[WIDTH-1]) begin
        pre_x = y_ext;
        pre_y = -x_ext;
        pre_z = HALF_PI_Z;
      end else begin
        pre_x = -y_ext;
        pre_y = x_ext;
        pre_z = -HALF_PI_Z;
      end
    end
    x_sh = x_r >>> cnt;
    y_sh = y_r >>> cnt;
    if (!y_r[WIDTH+1]) begin
      nx = x_r + y_sh;
      ny = y_r - x_sh;
      nz = z_r + atan_lut[cnt];
    end else begin
      nx = x_r - y_sh;
      ny = y_r + x_sh;
      nz = z_r - atan_lut[cnt];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      zero_r       <= 1'b0;
      x_r          <= '0;
      y_r          <= '0;
      z_r          <= '0;
      io_out_valid <= 1'b0;
      io_out_mag   <= '0;
      io_out_angle <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io_in_valid) begin
            x_r    <= pre_x;
            y_r    <= pre_y;
            z_r    <= pre_z;
            zero_r <= (io_in_x == '0) && (io_in_y == '0);
            cnt    <= '0;
            state  <= S_ROTATE;
          end
        end
        S_ROTATE: begin
          // cnt == ITER is the extra result-register cycle after the last micro-rotation
          if (cnt == CNT_W'(ITER)) begin
            io_out_mag   <= zero_r ? '0 : $unsigned(x_r);
            io_out_angle <= zero_r ? '0 : sat_angle(z_r);
            io_out_valid <= 1'b1;
            state        <= S_DONE;
          end else begin
            x_r <= nx;
            y_r <= ny;
            z_r <= nz;
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (io_out_ready) begin
            io_out_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
